countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/clock_pkg.sv | 21 ++
 rtl/bcd_down_digit.sv | 42 ++++
 rtl/countdown_timer.sv | 129 ++++++++++++
 tb/tb_countdown_timer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the countdown timer: FSM states, BCD digit limits
// and the preset clamp used when loading a digit.
package clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Largest value a units digit / a tens-of-sec-or-min digit may hold
    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

    // Saturate a preset digit to the digit's own maximum
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain. Decrements on dec, wrapping 0 -> MAX
// and raising borrow so the next more significant digit decrements too.
module bcd_down_digit
    import clock_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Load (clamped) takes priority over a decrement
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_val, MAX);
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
        end
    end

    // Digit register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.hh countdown timer. A start edge toggles run/pause, load copies the
// clamped preset while not running, and reaching 00:00.00 raises done for one
// cycle and holds alarm until the timer is restarted or reloaded.
module countdown_timer
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       load,
    input  logic [3:0] set_min_10,
    input  logic [3:0] set_min_1,
    input  logic [3:0] set_sec_10,
    input  logic [3:0] set_sec_1,
    input  logic [3:0] set_milli_10,
    input  logic [3:0] set_milli_1,
    output logic [3:0] min_10,
    output logic [3:0] min_1,
    output logic [3:0] sec_10,
    output logic [3:0] sec_1,
    output logic [3:0] milli_10,
    output logic [3:0] milli_1,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam int unsigned     TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned     DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             start_q;
    logic             running_q, done_q, alarm_q;

    logic             start_edge, tick, load_en, count_zero, count_one, expire;
    logic             b_milli_1, b_milli_10, b_sec_1, b_sec_10, b_min_1;
    logic             unused_borrow_min_10;

    assign start_edge = start && !start_q;
    assign tick       = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign load_en    = load && (state_q != ST_RUN);
    assign count_zero = ({min_10, min_1, sec_10, sec_1, milli_10, milli_1} == 24'h00_00_00);
    assign count_one  = ({min_10, min_1, sec_10, sec_1, milli_10, milli_1} == 24'h00_00_01);
    // The only decrement that lands on 00:00.00 is the one from 00:00.01
    assign expire     = tick && count_one;

    // Next-state and divider logic; load beats a simultaneous start edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!load && start_edge && !count_zero) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (expire)          state_d = ST_EXPIRED;
                else if (start_edge) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (load)            state_d = ST_IDLE;
                else if (start_edge) state_d = ST_RUN;
            end
            ST_EXPIRED: begin
                if (load || start_edge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Divider only advances while staying in RUN, so entry into RUN restarts it
        div_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // FSM state, divider, start-edge history and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            start_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            start_q   <= start;
            running_q <= (state_d == ST_RUN);
            done_q    <= expire;
            alarm_q   <= (state_d == ST_EXPIRED);
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;

    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_milli_1 (
        .clk(clk), .rst_n(reset), .dec(tick), .load(load_en), .load_val(set_milli_1),
        .digit(milli_1), .borrow(b_milli_1)
    );
    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_milli_10 (
        .clk(clk), .rst_n(reset), .dec(b_milli_1), .load(load_en), .load_val(set_milli_10),
        .digit(milli_10), .borrow(b_milli_10)
    );
    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_sec_1 (
        .clk(clk), .rst_n(reset), .dec(b_milli_10), .load(load_en), .load_val(set_sec_1),
        .digit(sec_1), .borrow(b_sec_1)
    );
    bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_sec_10 (
        .clk(clk), .rst_n(reset), .dec(b_sec_1), .load(load_en), .load_val(set_sec_10),
        .digit(sec_10), .borrow(b_sec_10)
    );
    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_min_1 (
        .clk(clk), .rst_n(reset), .dec(b_sec_10), .load(load_en), .load_val(set_min_1),
        .digit(min_1), .borrow(b_min_1)
    );
    // Minutes never underflow: the timer expires before 00:00.00 is decremented
    bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_min_10 (
        .clk(clk), .rst_n(reset), .dec(b_min_1), .load(load_en), .load_val(set_min_10),
        .digit(min_10), .borrow(unused_borrow_min_10)
    );

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a vector table, hand-written timing
// sequences, and randomized traffic against a hundredths-count reference model.
module tb_countdown_timer;

    localparam int unsigned CLK_HZ  = 1000;
    localparam int unsigned TICK_HZ = 100;
    localparam int          TDIV    = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load = 1'b0;
    logic [23:0] preset = '0;
    logic [3:0]  min_10, min_1, sec_10, sec_1, milli_10, milli_1;
    logic        running, done, alarm;
    logic [23:0] dut_cnt;

    int tests = 0;
    int fails = 0;

    countdown_timer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
        .clk(clk), .reset(reset), .start(start), .load(load),
        .set_min_10(preset[23:20]), .set_min_1(preset[19:16]),
        .set_sec_10(preset[15:12]), .set_sec_1(preset[11:8]),
        .set_milli_10(preset[7:4]), .set_milli_1(preset[3:0]),
        .min_10(min_10), .min_1(min_1), .sec_10(sec_10), .sec_1(sec_1),
        .milli_10(milli_10), .milli_1(milli_1),
        .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    assign dut_cnt = {min_10, min_1, sec_10, sec_1, milli_10, milli_1};

    // ---------------- reference model: remaining time in hundredths ----------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXPIRED} mmode_e;
    mmode_e m_mode;
    int     m_cnt;
    int     m_elapsed;
    bit     m_prev;
    bit     m_done;

    function automatic int clampd(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic int preset_hundredths(input logic [23:0] p);
        int mins, secs, hs;
        mins = clampd(int'(p[23:20]), 5) * 10 + clampd(int'(p[19:16]), 9);
        secs = clampd(int'(p[15:12]), 5) * 10 + clampd(int'(p[11:8]), 9);
        hs   = clampd(int'(p[7:4]), 9) * 10 + clampd(int'(p[3:0]), 9);
        return mins * 6000 + secs * 100 + hs;
    endfunction

    function automatic logic [23:0] to_bcd(input int c);
        int mn, s, h;
        mn = c / 6000;
        s  = (c / 100) % 60;
        h  = c % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_elapsed = 0; m_prev = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit edge_s;
        if (!reset) begin
            model_reset();
            return;
        end
        edge_s = start && !m_prev;
        m_prev = start;
        m_done = 0;
        case (m_mode)
            M_IDLE: begin
                if (load) m_cnt = preset_hundredths(preset);
                else if (edge_s && m_cnt != 0) begin m_mode = M_RUN; m_elapsed = 0; end
            end
            M_RUN: begin
                m_elapsed++;
                if (m_elapsed % TDIV == 0) m_cnt--;
                if (m_cnt == 0) begin m_mode = M_EXPIRED; m_done = 1; end
                else if (edge_s) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (load) begin m_mode = M_IDLE; m_cnt = preset_hundredths(preset); end
                else if (edge_s) begin m_mode = M_RUN; m_elapsed = 0; end
            end
            default: begin
                if (load) begin m_mode = M_IDLE; m_cnt = preset_hundredths(preset); end
                else if (edge_s) m_mode = M_IDLE;
            end
        endcase
    endtask

    // ---------------- helpers ------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [23:0] ecnt,
                         input logic erun, input logic edone, input logic ealarm);
        tests++;
        if ({dut_cnt, running, done, alarm} !== {ecnt, erun, edone, ealarm}) begin
            fails++;
            $display("FAIL %s: got cnt=%h run=%b done=%b alarm=%b, want cnt=%h run=%b done=%b alarm=%b",
                     name, dut_cnt, running, done, alarm, ecnt, erun, edone, ealarm);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check(name, to_bcd(m_cnt), m_mode == M_RUN, m_done, m_mode == M_EXPIRED);
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; load = 1'b0;
        repeat (2) cyc();
        check("reset_state", 24'h000000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // ---------------- vector table -------------------------------------------
    typedef struct {
        logic        st;
        logic        ld;
        logic [23:0] pre;
        int          n;
        logic [23:0] ecnt;
        logic [2:0]  ef;   // {running, done, alarm}
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    function automatic vec_t mk(input logic st, input logic ld, input logic [23:0] pre,
                                input int n, input logic [23:0] ecnt, input logic [2:0] ef);
        vec_t v;
        v.st = st; v.ld = ld; v.pre = pre; v.n = n; v.ecnt = ecnt; v.ef = ef;
        return v;
    endfunction

    initial begin
        int done_at, n_dec, gap_bad, last_dec, pulses;
        logic [23:0] prev;

        vt[0]  = mk(0, 1, 24'h000003,  1, 24'h000003, 3'b000);
        vt[1]  = mk(1, 0, 24'h000000,  1, 24'h000003, 3'b100);
        vt[2]  = mk(1, 0, 24'h000000,  9, 24'h000003, 3'b100);
        vt[3]  = mk(1, 0, 24'h000000,  1, 24'h000002, 3'b100);
        vt[4]  = mk(0, 0, 24'h000000, 10, 24'h000001, 3'b100);
        vt[5]  = mk(0, 0, 24'h000000,  9, 24'h000001, 3'b100);
        vt[6]  = mk(0, 0, 24'h000000,  1, 24'h000000, 3'b011);
        vt[7]  = mk(0, 0, 24'h000000,  1, 24'h000000, 3'b001);
        vt[8]  = mk(0, 1, 24'h7C7FAB,  1, 24'h595999, 3'b000);
        vt[9]  = mk(1, 1, 24'h000000,  1, 24'h000000, 3'b000);
        vt[10] = mk(0, 0, 24'h000000,  1, 24'h000000, 3'b000);
        vt[11] = mk(1, 0, 24'h000000,  1, 24'h000000, 3'b000);
        vt[12] = mk(0, 1, 24'h010000,  1, 24'h010000, 3'b000);
        vt[13] = mk(1, 0, 24'h000000, 10, 24'h010000, 3'b100);
        vt[14] = mk(1, 0, 24'h000000,  1, 24'h005999, 3'b100);
        vt[15] = mk(0, 0, 24'h000000,  1, 24'h005999, 3'b100);
        vt[16] = mk(1, 0, 24'h000000,  1, 24'h005999, 3'b000);
        vt[17] = mk(0, 0, 24'h000000,  1, 24'h005999, 3'b000);
        vt[18] = mk(1, 1, 24'h001000,  1, 24'h001000, 3'b000);
        vt[19] = mk(0, 0, 24'h000000,  1, 24'h001000, 3'b000);
        vt[20] = mk(1, 0, 24'h000000, 11, 24'h000999, 3'b100);

        model_reset();
        do_reset();
        for (int i = 0; i < NV; i++) begin
            start = vt[i].st; load = vt[i].ld; preset = vt[i].pre;
            repeat (vt[i].n) cyc();
            check($sformatf("vec%0d", i), vt[i].ecnt, vt[i].ef[2], vt[i].ef[1], vt[i].ef[0]);
        end
        start = 0; load = 0;

        // 00:00.05 counts down one hundredth every TDIV cycles, done at 5*TDIV
        do_reset();
        preset = 24'h000005; load = 1; cyc(); load = 0;
        start = 1; cyc();
        done_at = -1; n_dec = 0; gap_bad = 0; last_dec = 0; prev = dut_cnt;
        for (int k = 1; k <= 200; k++) begin
            cyc();
            if (dut_cnt != prev) begin
                n_dec++;
                if (k - last_dec != TDIV) gap_bad++;
                last_dec = k; prev = dut_cnt;
            end
            if (done) begin done_at = k; break; end
        end
        check_int("done_latency", done_at, 5 * TDIV);
        check_int("dec_count", n_dec, 5);
        check_int("dec_spacing_errors", gap_bad, 0);
        check("done_cycle", 24'h000000, 1'b0, 1'b1, 1'b1);
        cyc();
        check("after_done", 24'h000000, 1'b0, 1'b0, 1'b1);
        start = 0;

        // Pause at cycle 25, hold 100 cycles, resume: next tick TDIV after resume
        do_reset();
        preset = 24'h000500; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        repeat (24) cyc();
        start = 1; cyc(); start = 0;
        check("pause_entry", 24'h000498, 1'b0, 1'b0, 1'b0);
        repeat (100) cyc();
        check("pause_frozen", 24'h000498, 1'b0, 1'b0, 1'b0);
        start = 1; cyc(); start = 0;
        repeat (9) cyc();
        check("resume_before_tick", 24'h000498, 1'b1, 1'b0, 1'b0);
        cyc();
        check("resume_first_tick", 24'h000497, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a run
        do_reset();
        preset = 24'h000300; load = 1; cyc(); load = 0;
        start = 1; cyc(); start = 0;
        repeat (15) cyc();
        check("pre_reset_running", 24'h000299, 1'b1, 1'b0, 1'b0);
        #3 reset = 0;
        #1 check("async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
        cyc(); cyc();
        reset = 1;
        pulses = 0;
        repeat (20) begin cyc(); if (done) pulses++; end
        check_int("no_done_after_reset", pulses, 0);
        check("idle_after_reset", 24'h000000, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) start = ~start;
            load = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) preset = 24'($urandom);
            else preset = {12'h000, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15))};
            cyc();
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
